// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide side unit. Operands come from the register
//   file read ports; the result, destination address and write strobe go to the
//   register file write port. Fixed latency: mode iterations plus one FINISH
//   cycle, including the divide-by-zero and signed-overflow cases.
//
// Handshake (valid/ready): start is only accepted while busy=0 and flush=0.
//   A request is taken on the edge where start=1 and the unit is IDLE. The
//   unit answers with a single-cycle done pulse; result/rd_out are valid in
//   that cycle and hold afterwards. flush aborts at the next edge and masks
//   done/write in its own cycle. There is no back-pressure on done.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, flush          request / abort
//   op                    funct3 (0 MUL .. 7 REMU)
//   rs1_data, rs2_data    operands A and B
//   rd_in                 destination register of the request
//   busy                  state != IDLE
//   done                  one-cycle completion pulse
//   write                 register-file write enable (done and rd_out != 0)
//   rd_out, result        registered destination and result
//   dbg_state             current FSM state (0 IDLE, 1 CALC, 2 FINISH)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int mode       = 32,
  parameter int reg_number = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          flush,
  input  logic [2:0]                    op,
  input  logic [mode-1:0]               rs1_data,
  input  logic [mode-1:0]               rs2_data,
  input  logic [$clog2(reg_number):0]   rd_in,
  output logic                          busy,
  output logic                          done,
  output logic                          write,
  output logic [$clog2(reg_number):0]   rd_out,
  output logic [mode-1:0]               result,
  output logic [1:0]                    dbg_state
);

  localparam int CW = (mode > 1) ? $clog2(mode) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(mode - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_n;
  logic [CW-1:0]                 r_cnt;
  logic [2:0]                    r_op;
  logic [$clog2(reg_number):0]   r_rd;
  logic [mode-1:0]               r_hi;   // partial product high half / partial remainder
  logic [mode-1:0]               r_lo;   // multiplier / dividend-then-quotient
  logic [mode-1:0]               r_b;    // |B|: multiplicand or divisor
  logic                          r_sa;   // operand A was negative and treated signed
  logic                          r_sb;   // operand B was negative and treated signed
  logic                          r_div0;
  logic [mode-1:0]               r_result;
  logic [$clog2(reg_number):0]   r_rd_out;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic [mode-1:0] w_mag_a, w_mag_b;

  always_comb begin
    // A is signed for MUL, MULH, MULHSU, DIV, REM; B for MUL, MULH, DIV, REM.
    w_a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
                 (op == 3'd4) || (op == 3'd6);
    w_b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    w_sa       = w_a_signed & rs1_data[mode-1];
    w_sb       = w_b_signed & rs2_data[mode-1];
    w_mag_a    = w_sa ? (~rs1_data + 1'b1) : rs1_data;
    w_mag_b    = w_sb ? (~rs2_data + 1'b1) : rs2_data;
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply or restoring divide
  // ---------------------------------------------------------------------------
  logic [mode:0]   w_mul_sum;
  logic [mode:0]   w_div_shift;
  logic [mode:0]   w_div_diff;
  logic            w_div_ok;
  logic [mode-1:0] w_hi_n, w_lo_n;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(mode+1){1'b0}});
    w_div_shift = {r_hi, r_lo[mode-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
    // The partial remainder stays below the divisor, so bit mode of the
    // difference is set exactly when the trial subtraction borrows.
    w_div_ok    = ~w_div_diff[mode];
    if (r_op[2]) begin
      w_hi_n = w_div_ok ? w_div_diff[mode-1:0] : w_div_shift[mode-1:0];
      w_lo_n = {r_lo[mode-2:0], w_div_ok};
    end else begin
      // Product shifts right through {hi, lo}; carry-out enters the top.
      w_hi_n = w_mul_sum[mode:1];
      w_lo_n = {w_mul_sum[0], r_lo[mode-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign fix-up and selection, applied to the last iteration's values
  // ---------------------------------------------------------------------------
  logic [2*mode-1:0] w_prod, w_prod_s;
  logic [mode-1:0]   w_quo, w_rem, w_final;

  always_comb begin
    w_prod   = {w_hi_n, w_lo_n};
    w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    // With B = 0 the restoring loop leaves |A| in the remainder, so only the
    // quotient needs overriding. Signed overflow falls out naturally.
    w_quo    = r_div0 ? {mode{1'b1}}
                      : ((r_sa ^ r_sb) ? (~w_lo_n + 1'b1) : w_lo_n);
    w_rem    = r_sa ? (~w_hi_n + 1'b1) : w_hi_n;
    case (r_op)
      3'd0:          w_final = w_prod_s[mode-1:0];
      3'd1, 3'd2,
      3'd3:          w_final = w_prod_s[2*mode-1:mode];
      3'd4, 3'd5:    w_final = w_quo;
      default:       w_final = w_rem;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) w_state_n = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)                  w_state_n = S_IDLE;
        else if (r_cnt == LAST_CNT) w_state_n = S_FINISH;
      end
      S_FINISH: begin
        busy      = 1'b1;
        done      = ~flush;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign write     = done & (r_rd_out != '0);
  assign rd_out    = r_rd_out;
  assign result    = r_result;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_cnt  <= '0;
            r_op   <= op;
            r_rd   <= rd_in;
            r_hi   <= '0;
            r_lo   <= w_mag_a;
            r_b    <= w_mag_b;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_div0 <= (rs2_data == '0);
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            if (r_cnt == LAST_CNT) begin
              r_result <= w_final;
              r_rd_out <= r_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
